// File: rtl/diferential_rvb2_pkg.sv
// Shared constants for the diferential_rvb2 tile: instruction encodings,
// the fixed counter program held in ROM, and the 7-segment glyph table.
package diferential_rvb2_pkg;

    // Major opcodes recognised by the core
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] JAL    = 7'h6F;

    // funct3 selectors within the recognised opcodes
    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_AND = 3'd7;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Canonical NOP (addi x0,x0,0) fills the unused tail of the ROM
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam int ROM_DEPTH = 8;

    // Counter program: x1 counts, is masked to 4 bits and stored to the
    // display register, then the loop jumps back to the increment.
    localparam logic [31:0] ROM_WORDS [0:ROM_DEPTH-1] = '{
        32'h0000_0093,  // 0x00: addi x1,x0,0
        32'h0010_8093,  // 0x04: addi x1,x1,1
        32'h00F0_F093,  // 0x08: andi x1,x1,15
        32'h0010_2023,  // 0x0C: sw   x1,0(x0)
        32'hFF5F_F06F,  // 0x10: jal  x0,-12
        NOP_WORD,
        NOP_WORD,
        NOP_WORD
    };

    // Active-high segment patterns, bit0=a .. bit6=g, for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/rvb2_seg7.sv
// Hex digit to 7-segment decoder; purely combinational, zero latency.
module rvb2_seg7
    import diferential_rvb2_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    // Table lookup of the glyph for the current digit
    always_comb begin
        segments = SEG_TABLE[digit];
    end

endmodule

// File: rtl/diferential_rvb2.sv
// Tiny-tapeout tile wrapping a minimal RV32I-subset core that runs a fixed
// counter program from an internal ROM and shows the count on a 7-segment
// display. io_in[0] is the clock, io_in[1] a synchronous active-high reset.
// Optional build macro RVB2_DECIMAL_POINT_EN: when defined, the decimal
// point toggles on every store to the display address; otherwise io_out[7]
// is tied low and no decimal-point register exists.
module diferential_rvb2
    import diferential_rvb2_pkg::*;
(
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic       clk;
    logic       rst;
    logic [4:0] pc;
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] x3;
    logic [3:0] disp;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [7:0]  rs1_val;
    logic [7:0]  rs2_val;
    logic [31:0] store_addr;
    logic [4:0]  pc_next;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        store_hit;
    logic [6:0]  segments;
    logic        unused_bits;

    assign clk = io_in[0];
    assign rst = io_in[1];

    // Bits 7:2 of the tile input and most instruction fields are don't-care
    assign unused_bits = ^{io_in[7:2], instr};

    assign instr  = ROM_WORDS[pc[4:2]];
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    // Register file read ports; x0 and any register beyond x3 read as zero
    always_comb begin
        rs1_val = 8'd0;
        case (rs1)
            5'd1:    rs1_val = x1;
            5'd2:    rs1_val = x2;
            5'd3:    rs1_val = x3;
            default: rs1_val = 8'd0;
        endcase
        rs2_val = 8'd0;
        case (rs2)
            5'd1:    rs2_val = x1;
            5'd2:    rs2_val = x2;
            5'd3:    rs2_val = x3;
            default: rs2_val = 8'd0;
        endcase
    end

    // Store address is the full 32-bit sum of base and sign-extended offset
    assign store_addr = {24'd0, rs1_val}
                      + {{20{instr[31]}}, instr[31:25], instr[11:7]};

    // Decode and execute: pick the register write-back and next pc
    always_comb begin
        wr_en     = 1'b0;
        wr_data   = 8'd0;
        store_hit = 1'b0;
        pc_next   = pc + 5'd4;
        case (opcode)
            OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    wr_en   = 1'b1;
                    wr_data = rs1_val + instr[27:20];
                end else if (funct3 == F3_AND) begin
                    wr_en   = 1'b1;
                    wr_data = rs1_val & instr[27:20];
                end
            end
            STORE: begin
                if (funct3 == F3_SW && store_addr == 32'd0) begin
                    store_hit = 1'b1;
                end
            end
            JAL: begin
                wr_en   = 1'b1;
                wr_data = {3'd0, pc} + 8'd4;
                // Only imm[4:1] matters: the pc wraps within 32 bytes
                pc_next = pc + {instr[24:21], 1'b0};
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // Architectural state update, one instruction retired per clock
    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= 5'd0;
            x1   <= 8'd0;
            x2   <= 8'd0;
            x3   <= 8'd0;
            disp <= 4'd0;
        end else begin
            pc <= pc_next;
            if (wr_en) begin
                case (rd)
                    5'd1:    x1 <= wr_data;
                    5'd2:    x2 <= wr_data;
                    5'd3:    x3 <= wr_data;
                    default: ;
                endcase
            end
            if (store_hit) begin
                disp <= rs2_val[3:0];
            end
        end
    end

    rvb2_seg7 u_seg7 (
        .digit    (disp),
        .segments (segments)
    );

`ifdef RVB2_DECIMAL_POINT_EN
    logic dp;

    // Decimal point flips on every store that lands on the display address
    always_ff @(posedge clk) begin
        if (rst) begin
            dp <= 1'b0;
        end else if (store_hit) begin
            dp <= ~dp;
        end
    end

    assign io_out = {dp, segments};
`else
    assign io_out = {1'b0, segments};
`endif

endmodule

// File: tb/tb_diferential_rvb2.sv
// Self-checking bench for diferential_rvb2. The reference model only tracks
// how many edges have elapsed since reset: the counter program stores a new
// value every 4 edges, so the shown digit is (edges/4) mod 16 and the
// decimal point (when built) is the parity of the number of stores.
module tb_diferential_rvb2;

    logic       clk;
    logic       rst;
    logic [5:0] junk;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int compared;
    int mismatched;
    int edges_since_reset;

    logic [6:0] glyphs [0:15];

    assign io_in = {junk, rst, clk};

    diferential_rvb2 dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    // Free-running clock on io_in[0]
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] model_seg(input int n);
        return glyphs[(n / 4) % 16];
    endfunction

    function automatic logic model_dp(input int n);
`ifdef RVB2_DECIMAL_POINT_EN
        return ((n / 4) % 2) == 1;
`else
        return n < 0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
        end
    endtask

    // One clock edge with the given reset level and random junk on io_in[7:2],
    // then check segments and decimal point against the model
    task automatic applyStimulus(input logic r);
        rst  = r;
        junk = 6'($urandom);
        @(posedge clk);
        #1;
        if (r) edges_since_reset = 0;
        else   edges_since_reset++;
        checkOutput("seg_model", {1'b0, io_out[6:0]},
                    {1'b0, model_seg(edges_since_reset)});
        checkOutput("dp_model", {7'd0, io_out[7]},
                    {7'd0, model_dp(edges_since_reset)});
    endtask

    initial begin
        glyphs = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        compared          = 0;
        mismatched        = 0;
        edges_since_reset = 0;
        rst  = 1'b1;
        junk = 6'd0;

        // Reset held for three edges
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        checkOutput("reset_seg", {1'b0, io_out[6:0]}, 8'h3F);
        checkOutput("reset_dp", {7'd0, io_out[7]}, 8'h00);

        // Clean run after release, spot-checking the documented milestones
        for (int e = 1; e <= 70; e++) begin
            applyStimulus(1'b0);
            case (e)
                3:  checkOutput("edge3",  {1'b0, io_out[6:0]}, 8'h3F);
                4:  checkOutput("edge4",  {1'b0, io_out[6:0]}, 8'h06);
                8:  checkOutput("edge8",  {1'b0, io_out[6:0]}, 8'h5B);
                12: checkOutput("edge12", {1'b0, io_out[6:0]}, 8'h4F);
                60: checkOutput("edge60", {1'b0, io_out[6:0]}, 8'h71);
                64: checkOutput("edge64_wrap", {1'b0, io_out[6:0]}, 8'h3F);
                68: checkOutput("edge68", {1'b0, io_out[6:0]}, 8'h06);
                default: ;
            endcase
`ifdef RVB2_DECIMAL_POINT_EN
            if (e == 4)  checkOutput("dp_edge4",  {7'd0, io_out[7]}, 8'h01);
            if (e == 8)  checkOutput("dp_edge8",  {7'd0, io_out[7]}, 8'h00);
            if (e == 12) checkOutput("dp_edge12", {7'd0, io_out[7]}, 8'h01);
`else
            checkOutput("dp_tied_low", {7'd0, io_out[7]}, 8'h00);
`endif
        end

        // Mid-run reset pulse at edge 10 of a fresh run
        applyStimulus(1'b1);
        for (int e = 1; e <= 10; e++) applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("midreset_seg", {1'b0, io_out[6:0]}, 8'h3F);
        for (int e = 1; e <= 4; e++) begin
            applyStimulus(1'b0);
            if (e == 3) checkOutput("midreset_e3", {1'b0, io_out[6:0]}, 8'h3F);
            if (e == 4) checkOutput("midreset_e4", {1'b0, io_out[6:0]}, 8'h06);
        end

        // Random reset pulses and random junk on the unused inputs
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 39) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
